// File: rtl/seq_shifter.sv
// Multi-cycle shifter: shifts a WIDTH-bit operand by 0..2^AMT_W-1 positions,
// one bit per clock, with valid/ready handshakes on both operand and result.
module seq_shifter #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       shift,
    input  logic [AMT_W-1:0] amount,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sout,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] data_reg, data_nxt;
    logic [AMT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       op, op_nxt;
    logic [WIDTH-1:0] step;

    // Arithmetic right takes its fill from the current MSB, so repeated
    // steps keep replicating the original sign bit.
    always_comb begin
        step = data_reg;
        unique case (op)
            2'b01:   step = {data_reg[WIDTH-2:0], 1'b0};
            2'b10:   step = {1'b0, data_reg[WIDTH-1:1]};
            2'b11:   step = {data_reg[WIDTH-1], data_reg[WIDTH-1:1]};
            default: step = data_reg;
        endcase
    end

    always_comb begin
        state_nxt = state;
        data_nxt  = data_reg;
        cnt_nxt   = cnt;
        op_nxt    = op;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    data_nxt = in_data;
                    cnt_nxt  = amount;
                    op_nxt   = shift;
                    if (amount == '0 || shift == 2'b00) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                data_nxt = step;
                cnt_nxt  = cnt - AMT_W'(1);
                if (cnt == AMT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            data_reg <= '0;
            cnt      <= '0;
            op       <= 2'b00;
        end else begin
            state    <= state_nxt;
            data_reg <= data_nxt;
            cnt      <= cnt_nxt;
            op       <= op_nxt;
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = !in_ready;
    assign out_valid = (state == DONE);
    assign sout      = data_reg;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed cases, backpressure, reset
// abort and randomized operations against an arithmetic reference model.
module tb_seq_shifter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  shift;
    logic [3:0]  amount;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sout;
    logic        busy;

    int checks = 0;
    int errors = 0;

    seq_shifter #(.WIDTH(16), .AMT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .shift     (shift),
        .amount    (amount),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sout      (sout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [15:0] d, input logic [1:0] sh,
                                          input logic [3:0] a);
        logic signed [15:0] sd;
        sd = d;
        case (sh)
            2'b01:   return d << a;
            2'b10:   return d >> a;
            2'b11:   return sd >>> a;
            default: return d;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, hold the result for 'hold' cycles, then hand off.
    task automatic do_op(input logic [15:0] d, input logic [1:0] sh, input logic [3:0] a,
                         input int hold);
        logic [15:0] exp;
        int lat;
        int n;
        exp = model(d, sh, a);
        lat = (sh == 2'b00) ? 0 : int'(a);
        in_valid  = 1'b1;
        in_data   = d;
        shift     = sh;
        amount    = a;
        out_ready = (hold == 0);
        chk("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        shift    = 2'($urandom);
        amount   = 4'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, lat);
        chk("sout", {16'b0, sout}, {16'b0, exp});
        chk("busy_in_done", {31'b0, busy}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_sout", {16'b0, sout}, {16'b0, exp});
            chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("after_handoff_out_valid", {31'b0, out_valid}, 32'd0);
        chk("after_handoff_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        shift     = 2'b00;
        amount    = '0;
        out_ready = 1'b0;
        #12;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_sout", {16'b0, sout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        do_op(16'h000F, 2'b01, 4'd3, 0);
        do_op(16'hE381, 2'b11, 4'd4, 0);
        do_op(16'hE381, 2'b10, 4'd4, 0);
        do_op(16'h8000, 2'b10, 4'd15, 0);
        do_op(16'h8000, 2'b11, 4'd15, 0);
        do_op(16'h0001, 2'b01, 4'd15, 0);
        do_op(16'h1234, 2'b01, 4'd0, 0);
        do_op(16'h1234, 2'b00, 4'd9, 0);
        chk("model_asr_ref", {16'b0, model(16'hE381, 2'b11, 4'd4)}, 32'h0000FE38);

        // Backpressure with a second operand already waiting
        in_valid  = 1'b1;
        in_data   = 16'h00F0;
        shift     = 2'b10;
        amount    = 4'd2;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_data = 16'h0ABC;
        shift   = 2'b01;
        amount  = 4'd1;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_latency", n, 2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_sout", {16'b0, sout}, 32'h003C);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_handoff_idle", {31'b0, in_ready}, 32'd1);
        chk("bp_handoff_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("bp_second_accepted", {31'b0, busy}, 32'd1);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_second_latency", n, 1);
        chk("bp_second_sout", {16'b0, sout}, 32'h1578);
        @(posedge clk); #1;
        chk("bp_second_done", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b0;

        // Reset in the middle of an operation
        in_valid = 1'b1;
        in_data  = 16'h1234;
        shift    = 2'b01;
        amount   = 4'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_sout", {16'b0, sout}, 32'd0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("abort_no_output", seen, 0);

        // Randomized operations, with random result backpressure
        for (int i = 0; i < 40; i++) begin
            do_op(16'($urandom), 2'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
